// File: rtl/btn_debounce_array.sv
// N-channel push-button conditioner: 2-flop synchroniser, debounce FSM and press/release strobes per channel.
// Define BTN_REPEAT_EN to add a per-channel auto-repeat strobe on BTN_REPEAT while a button is held.
module btn_debounce_array #(
  parameter int N_BTN         = 5,
  parameter int DB_CYCLES     = 1500000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE,
  output logic [N_BTN-1:0] BTN_REPEAT
);

  localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  logic [N_BTN-1:0] s1_q, s2_q;
  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
      unique case (state_q[i])
        IDLE: begin
          if (s2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
            state_d[i] = HELD;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        HELD: begin
          if (!s2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s2_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
            state_d[i]   = IDLE;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      // Level is registered from the next state so it rises with the press strobe.
      level_d[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_WAIT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      // NOTE: these per-channel arrays are small flop banks, so each entry is reset explicitly.
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q      <= BTN_IN;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign BTN_LEVEL   = level_q;
  assign BTN_PRESS   = press_q;
  assign BTN_RELEASE = release_q;

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);

  logic [RPT_W-1:0] rpt_cnt_q [N_BTN];
  logic [RPT_W-1:0] rpt_cnt_d [N_BTN];
  logic [N_BTN-1:0] rpt_first_q, rpt_first_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;

  // The counter runs while the channel stays held; rpt_first marks that the initial delay has elapsed.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      rpt_first_d[i] = rpt_first_q[i];
      repeat_d[i]    = 1'b0;
      if ((state_q[i] == HELD || state_q[i] == RELEASE_WAIT) && state_d[i] != IDLE) begin
        if (rpt_cnt_q[i] == (rpt_first_q[i] ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1))) begin
          repeat_d[i]    = 1'b1;
          rpt_cnt_d[i]   = '0;
          rpt_first_d[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
        end
      end else begin
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rpt_first_q <= '0;
      repeat_q    <= '0;
      for (int i = 0; i < N_BTN; i++) rpt_cnt_q[i] <= '0;
    end else begin
      rpt_first_q <= rpt_first_d;
      repeat_q    <= repeat_d;
      for (int i = 0; i < N_BTN; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end

  assign BTN_REPEAT = repeat_q;
`else
  assign BTN_REPEAT = '0;
`endif

endmodule
